// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared FSM encoding, field limits and cursor codes for the time editor
package rtc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam logic [7:0] HOUR_MAX   = 8'h23;
    localparam logic [7:0] MINSEC_MAX = 8'h59;

    localparam logic [1:0] FIELD_HH = 2'd0;
    localparam logic [1:0] FIELD_MM = 2'd1;
    localparam logic [1:0] FIELD_SS = 2'd2;

    // Snapshot bytes that are not legal BCD for their field start the edit at 00.
    function automatic logic [7:0] clamp_bcd(input logic [7:0] value, input logic [7:0] max_value);
        logic [7:0] result;
        result = value;
        if (value[7:4] > 4'd9 || value[3:0] > 4'd9 || value > max_value) begin
            result = 8'h00;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_wrap_step.sv
// rtl/bcd_wrap_step.sv - one BCD up/down step on a byte with wrap between 00 and max
module bcd_wrap_step (
    input  logic [7:0] value_in,
    input  logic [7:0] max_value,
    input  logic       up,
    input  logic       down,
    output logic [7:0] value_out
);

    always_comb begin
        value_out = value_in;
        if (up && !down) begin
            if (value_in >= max_value) begin
                value_out = 8'h00;
            end else if (value_in[3:0] >= 4'd9) begin
                value_out = {value_in[7:4] + 4'd1, 4'd0};
            end else begin
                value_out = {value_in[7:4], value_in[3:0] + 4'd1};
            end
        end else if (down && !up) begin
            if (value_in == 8'h00 || value_in > max_value) begin
                value_out = max_value;
            end else if (value_in[3:0] == 4'd0) begin
                value_out = {value_in[7:4] - 4'd1, 4'd9};
            end else begin
                value_out = {value_in[7:4], value_in[3:0] - 4'd1};
            end
        end
    end

endmodule

// File: rtl/hour_edit_ctrl.sv
// rtl/hour_edit_ctrl.sv - live/edit time source for the hour renderer with RTC write-back handshake
module hour_edit_ctrl
    import rtc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       programar_on,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic [7:0] rtc_hour_in1,
    input  logic [7:0] rtc_hour_in2,
    input  logic [7:0] rtc_hour_in3,
    input  logic       rtc_valid,
    output logic [7:0] hour_out1,
    output logic [7:0] hour_out2,
    output logic [7:0] hour_out3,
    output logic [3:0] direccion_actual_pantalla,
    output logic       wr_req,
    output logic [7:0] wr_data1,
    output logic [7:0] wr_data2,
    output logic [7:0] wr_data3,
    input  logic       wr_ack
);

    state_e     state_q, state_d;
    logic [7:0] hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
    logic [1:0] cursor_q, cursor_d;
    logic       wr_req_q, wr_req_d;
    logic [7:0] wd1_q, wd1_d, wd2_q, wd2_d, wd3_q, wd3_d;

    logic [7:0] field_val, field_max, field_next;

    // The single stepper works on whichever field the cursor points at.
    always_comb begin
        field_val = hh_q;
        field_max = HOUR_MAX;
        case (cursor_q)
            FIELD_MM: begin
                field_val = mm_q;
                field_max = MINSEC_MAX;
            end
            FIELD_SS: begin
                field_val = ss_q;
                field_max = MINSEC_MAX;
            end
            default: ;
        endcase
    end

    bcd_wrap_step u_step (
        .value_in  (field_val),
        .max_value (field_max),
        .up        (btn_up),
        .down      (btn_down),
        .value_out (field_next)
    );

    always_comb begin
        state_d  = state_q;
        hh_d     = hh_q;
        mm_d     = mm_q;
        ss_d     = ss_q;
        cursor_d = cursor_q;
        wr_req_d = wr_req_q;
        wd1_d    = wd1_q;
        wd2_d    = wd2_q;
        wd3_d    = wd3_q;
        case (state_q)
            ST_IDLE: begin
                cursor_d = FIELD_HH;
                if (programar_on) begin
                    state_d = ST_EDIT;
                    hh_d    = clamp_bcd(hh_q, HOUR_MAX);
                    mm_d    = clamp_bcd(mm_q, MINSEC_MAX);
                    ss_d    = clamp_bcd(ss_q, MINSEC_MAX);
                end else if (rtc_valid) begin
                    hh_d = rtc_hour_in1;
                    mm_d = rtc_hour_in2;
                    ss_d = rtc_hour_in3;
                end
            end
            ST_EDIT: begin
                if (!programar_on) begin
                    // Buttons in the leaving cycle are dropped; the write carries the settled values.
                    state_d  = ST_COMMIT;
                    wr_req_d = 1'b1;
                    wd1_d    = hh_q;
                    wd2_d    = mm_q;
                    wd3_d    = ss_q;
                end else begin
                    case (cursor_q)
                        FIELD_MM: mm_d = field_next;
                        FIELD_SS: ss_d = field_next;
                        default:  hh_d = field_next;
                    endcase
                    if (btn_right && !btn_left) begin
                        cursor_d = (cursor_q == FIELD_SS) ? FIELD_HH : cursor_q + 2'd1;
                    end else if (btn_left && !btn_right) begin
                        cursor_d = (cursor_q == FIELD_HH) ? FIELD_SS : cursor_q - 2'd1;
                    end
                end
            end
            ST_COMMIT: begin
                if (wr_ack) begin
                    state_d  = ST_IDLE;
                    wr_req_d = 1'b0;
                    cursor_d = FIELD_HH;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                wr_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            hh_q     <= 8'h00;
            mm_q     <= 8'h00;
            ss_q     <= 8'h00;
            cursor_q <= FIELD_HH;
            wr_req_q <= 1'b0;
            wd1_q    <= 8'h00;
            wd2_q    <= 8'h00;
            wd3_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            hh_q     <= hh_d;
            mm_q     <= mm_d;
            ss_q     <= ss_d;
            cursor_q <= cursor_d;
            wr_req_q <= wr_req_d;
            wd1_q    <= wd1_d;
            wd2_q    <= wd2_d;
            wd3_q    <= wd3_d;
        end
    end

    assign hour_out1                 = hh_q;
    assign hour_out2                 = mm_q;
    assign hour_out3                 = ss_q;
    assign direccion_actual_pantalla = {2'b00, cursor_q};
    assign wr_req                    = wr_req_q;
    assign wr_data1                  = wd1_q;
    assign wr_data2                  = wd2_q;
    assign wr_data3                  = wd3_q;

endmodule

// File: tb/tb_hour_edit_ctrl.sv
// tb/tb_hour_edit_ctrl.sv - bench for hour_edit_ctrl against a decimal-arithmetic reference model
module tb_hour_edit_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       programar_on = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [7:0] rtc_hour_in1 = 8'h00, rtc_hour_in2 = 8'h00, rtc_hour_in3 = 8'h00;
    logic       rtc_valid = 1'b0;
    logic       wr_ack = 1'b0;
    logic [7:0] hour_out1, hour_out2, hour_out3;
    logic [3:0] direccion_actual_pantalla;
    logic       wr_req;
    logic [7:0] wr_data1, wr_data2, wr_data3;

    hour_edit_ctrl dut (
        .clk                       (clk),
        .reset                     (reset),
        .programar_on              (programar_on),
        .btn_up                    (btn_up),
        .btn_down                  (btn_down),
        .btn_left                  (btn_left),
        .btn_right                 (btn_right),
        .rtc_hour_in1              (rtc_hour_in1),
        .rtc_hour_in2              (rtc_hour_in2),
        .rtc_hour_in3              (rtc_hour_in3),
        .rtc_valid                 (rtc_valid),
        .hour_out1                 (hour_out1),
        .hour_out2                 (hour_out2),
        .hour_out3                 (hour_out3),
        .direccion_actual_pantalla (direccion_actual_pantalla),
        .wr_req                    (wr_req),
        .wr_data1                  (wr_data1),
        .wr_data2                  (wr_data2),
        .wr_data3                  (wr_data3),
        .wr_ack                    (wr_ack)
    );

    always #5 clk = ~clk;

    localparam int MODE_IDLE = 0, MODE_EDIT = 1, MODE_COMMIT = 2;

    int         n_checks = 0;
    int         n_fail = 0;
    bit         chk_en = 1'b0;

    int         m_mode;
    logic [7:0] m_out [3];
    int         m_cur;
    logic       m_req;
    logic [7:0] m_wd [3];

    function automatic int dec(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] enc(input int x);
        return 8'((x / 10) * 16 + (x % 10));
    endfunction

    function automatic int modulus(input int field);
        return (field == 0) ? 24 : 60;
    endfunction

    function automatic bit legal(input logic [7:0] b, input int field);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (dec(b) < modulus(field));
    endfunction

    task automatic model_reset();
        m_mode = MODE_IDLE;
        m_cur  = 0;
        m_req  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_out[i] = 8'h00;
            m_wd[i]  = 8'h00;
        end
    endtask

    task automatic model_step();
        int delta, move;
        case (m_mode)
            MODE_IDLE: begin
                if (programar_on) begin
                    for (int i = 0; i < 3; i++) if (!legal(m_out[i], i)) m_out[i] = 8'h00;
                    m_mode = MODE_EDIT;
                    m_cur  = 0;
                end else if (rtc_valid) begin
                    m_out[0] = rtc_hour_in1;
                    m_out[1] = rtc_hour_in2;
                    m_out[2] = rtc_hour_in3;
                end
            end
            MODE_EDIT: begin
                if (!programar_on) begin
                    m_mode = MODE_COMMIT;
                    m_req  = 1'b1;
                    for (int i = 0; i < 3; i++) m_wd[i] = m_out[i];
                end else begin
                    delta = int'(btn_up) - int'(btn_down);
                    m_out[m_cur] = enc((dec(m_out[m_cur]) + delta + modulus(m_cur)) % modulus(m_cur));
                    move  = int'(btn_right) - int'(btn_left);
                    m_cur = (m_cur + move + 3) % 3;
                end
            end
            default: begin
                if (wr_ack) begin
                    m_mode = MODE_IDLE;
                    m_req  = 1'b0;
                    m_cur  = 0;
                end
            end
        endcase
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("hour_out1", hour_out1, m_out[0]);
            chk("hour_out2", hour_out2, m_out[1]);
            chk("hour_out3", hour_out3, m_out[2]);
            chk("cursor", {4'h0, direccion_actual_pantalla}, 8'(m_cur));
            chk("wr_req", {7'h0, wr_req}, {7'h0, m_req});
            chk("wr_data1", wr_data1, m_wd[0]);
            chk("wr_data2", wr_data2, m_wd[1]);
            chk("wr_data3", wr_data3, m_wd[2]);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        rtc_valid = 1'b0;
        wr_ack    = 1'b0;
    endtask

    task automatic rtc(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        rtc_hour_in1 = a;
        rtc_hour_in2 = b;
        rtc_hour_in3 = c;
        rtc_valid    = 1'b1;
        tick();
    endtask

    task automatic press(input bit up, input bit dn, input bit l, input bit r);
        btn_up    = up;
        btn_down  = dn;
        btn_left  = l;
        btn_right = r;
        tick();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset hour_out1", hour_out1, 8'h00);
        chk("reset wr_req", {7'h0, wr_req}, 8'h00);
        reset = 1'b1;
        @(negedge clk);

        rtc(8'h12, 8'h34, 8'h56);
        chk("pass hh", hour_out1, 8'h12);
        chk("pass mm", hour_out2, 8'h34);
        chk("pass ss", hour_out3, 8'h56);
        chk("pass cursor", {4'h0, direccion_actual_pantalla}, 8'h00);

        rtc(8'h23, 8'h59, 8'h59);
        programar_on = 1'b1;
        tick();
        chk("snap hh", hour_out1, 8'h23);
        press(1, 0, 0, 0);
        chk("hh wrap up", hour_out1, 8'h00);
        chk("mm kept", hour_out2, 8'h59);
        press(0, 1, 0, 0);
        chk("hh wrap down", hour_out1, 8'h23);
        press(0, 0, 1, 0);
        chk("cursor left wrap", {4'h0, direccion_actual_pantalla}, 8'h02);
        press(1, 0, 0, 0);
        chk("ss wrap up", hour_out3, 8'h00);
        press(0, 0, 0, 1);
        chk("cursor right wrap", {4'h0, direccion_actual_pantalla}, 8'h00);
        press(1, 1, 0, 0);
        chk("up+down hold", hour_out1, 8'h23);

        repeat (9) press(1, 0, 0, 0);
        press(0, 0, 0, 1);
        repeat (16) press(1, 0, 0, 0);
        chk("edit hh", hour_out1, 8'h08);
        chk("edit mm", hour_out2, 8'h15);
        programar_on = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("commit req", {7'h0, wr_req}, 8'h01);
            chk("commit d1", wr_data1, 8'h08);
            chk("commit d2", wr_data2, 8'h15);
            chk("commit d3", wr_data3, 8'h00);
            tick();
        end
        wr_ack = 1'b1;
        tick();
        chk("ack drops req", {7'h0, wr_req}, 8'h00);
        rtc(8'h11, 8'h22, 8'h33);
        chk("idle again", hour_out2, 8'h22);

        rtc(8'h9A, 8'h34, 8'h56);
        programar_on = 1'b1;
        tick();
        chk("clamp hh", hour_out1, 8'h00);
        chk("clamp keeps mm", hour_out2, 8'h34);

        programar_on = 1'b0;
        tick();
        chk("mid req up", {7'h0, wr_req}, 8'h01);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("async req drop", {7'h0, wr_req}, 8'h00);
        chk("async hh clear", hour_out1, 8'h00);
        chk("async wd clear", wr_data2, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no req after reset", {7'h0, wr_req}, 8'h00);
        end

        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 15) == 0) programar_on = ~programar_on;
            btn_up    = ($urandom_range(0, 3) == 0);
            btn_down  = ($urandom_range(0, 3) == 0);
            btn_left  = ($urandom_range(0, 3) == 0);
            btn_right = ($urandom_range(0, 3) == 0);
            rtc_valid = ($urandom_range(0, 1) == 0);
            wr_ack    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) begin
                rtc_hour_in1 = 8'($urandom);
                rtc_hour_in2 = 8'($urandom);
                rtc_hour_in3 = 8'($urandom);
            end else begin
                rtc_hour_in1 = enc(int'($urandom_range(0, 23)));
                rtc_hour_in2 = enc(int'($urandom_range(0, 59)));
                rtc_hour_in3 = enc(int'($urandom_range(0, 59)));
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
